// File: rtl/servo_pkg.sv
// servo_pkg: shared definitions for the servo PWM stage.
//   - estado_t : states of the sample update FSM.
//   - CENTRO   : mid-scale 12-bit sample, used as the reset content of the
//                averaging window (servo centred until real samples arrive).
//   - DEF_*    : default timing constants (50 MHz clock, 50 Hz servo frame).
package servo_pkg;

    typedef enum logic [1:0] {
        S_ESPERA = 2'd0,
        S_SUMA   = 2'd1,
        S_ESCALA = 2'd2
    } estado_t;

    localparam logic [11:0] CENTRO      = 12'd2048;
    // Sum of a window filled with CENTRO.
    localparam logic [13:0] SUMA_CENTRO = 14'd8192;

    localparam int unsigned DEF_PERIODO_CYC = 1_000_000;
    localparam int unsigned DEF_MIN_CYC     = 50_000;
    localparam int unsigned DEF_MAX_CYC     = 100_000;
    localparam int unsigned DEF_ESCALA      = 12;
    localparam int unsigned DEF_CNT_W       = 20;

endpackage

// File: rtl/servo_pwm_promedio4.sv
// promedio4: 4-entry shift window of 12-bit samples with a running sum.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (window -> CENTRO)
//   en       : shift dato in, discarding the oldest entry
//   dato     : 12-bit sample to insert
//   suma     : 14-bit sum of the four window entries
module promedio4
    import servo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] dato,
    output logic [13:0] suma
);

    // ventana[0] is the newest entry, ventana[3] the oldest.
    logic [3:0][11:0] ventana;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                ventana[i] <= CENTRO;
            end
            suma <= SUMA_CENTRO;
        end else if (en) begin
            ventana[0] <= dato;
            ventana[1] <= ventana[0];
            ventana[2] <= ventana[1];
            ventana[3] <= ventana[2];
            // Running sum: add the incoming sample, drop the outgoing one.
            // Intermediate wrap in 14 bits cancels out; the true sum always fits.
            suma <= suma + {2'b00, dato} - {2'b00, ventana[3]};
        end
    end

endmodule

// File: rtl/servo_pwm.sv
// servo_pwm: captures completed 12-bit samples from the ADC receiver,
// averages the last four, scales the average to a servo pulse width and
// drives a fixed-period PWM. Width changes are applied only at the period
// boundary so no period is ever truncated or stretched.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   rx_listo      : receiver frame-done level (may be held for many cycles)
//   paquete_bits  : received sample, valid while rx_listo=1
//   pwm           : registered servo drive
//   ancho_pulso   : pulse width currently applied (cycles)
//   fin_periodo   : high on the last cycle of each period
//   muestra_nueva : one-cycle pulse after the pending width is updated
module servo_pwm
    import servo_pkg::*;
#(
    parameter int unsigned PERIODO_CYC = DEF_PERIODO_CYC,
    parameter int unsigned MIN_CYC     = DEF_MIN_CYC,
    parameter int unsigned MAX_CYC     = DEF_MAX_CYC,
    parameter int unsigned ESCALA      = DEF_ESCALA,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_listo,
    input  logic [11:0]      paquete_bits,
    output logic             pwm,
    output logic [CNT_W-1:0] ancho_pulso,
    output logic             fin_periodo,
    output logic             muestra_nueva
);

    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(PERIODO_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_W  = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0] MAX_W  = CNT_W'(MAX_CYC);
    localparam logic [CNT_W-1:0] ESC_W  = CNT_W'(ESCALA);
    localparam logic [CNT_W-1:0] ANCHO_CENTRO =
        CNT_W'(MIN_CYC + 32'(CENTRO) * ESCALA);

    // ---------------------------------------------------------------
    // Capture: rising edge of rx_listo, accepted only while idle.
    // ---------------------------------------------------------------
    logic        rx_prev;
    logic        captura;
    logic        acepta;
    logic [11:0] muestra;

    estado_t estado, estado_sig;

    assign captura = rx_listo && !rx_prev;
    assign acepta  = captura && (estado == S_ESPERA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_prev <= 1'b0;
            muestra <= CENTRO;
        end else begin
            rx_prev <= rx_listo;
            if (acepta) begin
                muestra <= paquete_bits;
            end
        end
    end

    // ---------------------------------------------------------------
    // Update FSM: ESPERA -> SUMA (shift window) -> ESCALA (load width).
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= S_ESPERA;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            S_ESPERA: if (captura) estado_sig = S_SUMA;
            S_SUMA:   estado_sig = S_ESCALA;
            S_ESCALA: estado_sig = S_ESPERA;
            default:  estado_sig = S_ESPERA;
        endcase
    end

    // ---------------------------------------------------------------
    // Moving average and linear scaling with upper clamp.
    // ---------------------------------------------------------------
    logic [13:0]      suma;
    logic [13:0]      prom;
    logic [CNT_W-1:0] producto;
    logic [CNT_W-1:0] ancho_bruto;
    logic [CNT_W-1:0] ancho_calc;

    promedio4 u_promedio4 (
        .clk  (clk),
        .rst  (rst),
        .en   (estado == S_SUMA),
        .dato (muestra),
        .suma (suma)
    );

    assign prom        = suma >> 2;
    assign producto    = CNT_W'(prom) * ESC_W;
    assign ancho_bruto = MIN_W + producto;
    assign ancho_calc  = (ancho_bruto > MAX_W) ? MAX_W : ancho_bruto;

    logic [CNT_W-1:0] ancho_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ancho_pend    <= ANCHO_CENTRO;
            muestra_nueva <= 1'b0;
        end else begin
            muestra_nueva <= (estado == S_ESCALA);
            if (estado == S_ESCALA) begin
                ancho_pend <= ancho_calc;
            end
        end
    end

    // ---------------------------------------------------------------
    // PWM period counter and output.
    // ---------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ancho_act;

    assign fin_periodo = (cnt == ULTIMO);
    assign ancho_pulso = ancho_act;

    // The wrap samples ancho_pend before a same-cycle ESCALA update lands,
    // so a coincident update is deferred to the following period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            ancho_act <= ANCHO_CENTRO;
            pwm       <= 1'b0;
        end else begin
            if (fin_periodo) begin
                cnt       <= '0;
                ancho_act <= ancho_pend;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            pwm <= (cnt < ancho_act);
        end
    end

endmodule

// File: tb/tb_servo_pwm.sv
// Randomized self-checking bench for servo_pwm with a reduced period so the
// run stays short. The reference model keeps the last four samples in a
// queue, computes the width arithmetically and tracks, per clock edge index,
// when updates land and when periods wrap.
module tb_servo_pwm;

    localparam int P    = 4200;
    localparam int MINC = 100;
    localparam int MAXC = 4000;
    localparam int ESC  = 1;
    localparam int W    = 13;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx_listo = 1'b0;
    logic [11:0]  paquete_bits = '0;
    logic         pwm;
    logic [W-1:0] ancho_pulso;
    logic         fin_periodo;
    logic         muestra_nueva;

    servo_pwm #(
        .PERIODO_CYC (P),
        .MIN_CYC     (MINC),
        .MAX_CYC     (MAXC),
        .ESCALA      (ESC),
        .CNT_W       (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_listo      (rx_listo),
        .paquete_bits  (paquete_bits),
        .pwm           (pwm),
        .ancho_pulso   (ancho_pulso),
        .fin_periodo   (fin_periodo),
        .muestra_nueva (muestra_nueva)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    int win[$];
    int k;
    int m_pend, m_applied, m_new;
    int upd_edge, last_cap;
    bit m_rx_prev;
    int hi_cnt, shape_err, fin_cnt, fin_err;
    int mn_seen = 0;
    int mn_exp  = 0;

    function automatic int ancho_de_ventana();
        int s = 0;
        int w;
        foreach (win[i]) s += win[i];
        w = MINC + (s / 4) * ESC;
        return (w > MAXC) ? MAXC : w;
    endfunction

    task automatic model_reset();
        win = '{2048, 2048, 2048, 2048};
        m_pend    = ancho_de_ventana();
        m_applied = m_pend;
        k         = 0;
        upd_edge  = -1;
        last_cap  = -100;
        m_rx_prev = 1'b0;
        hi_cnt    = 0;
        shape_err = 0;
        fin_cnt   = 0;
        fin_err   = 0;
    endtask

    // One clock edge: sample outputs, advance the model.
    task automatic step();
        bit          rx_d = rx_listo;
        logic [11:0] d    = paquete_bits;
        bit          exp_pwm;
        @(posedge clk);
        #1;
        k++;
        exp_pwm = (((k - 1) % P) < m_applied);
        if (pwm !== exp_pwm) shape_err++;
        if (pwm) hi_cnt++;
        if (fin_periodo !== ((k % P) == P - 1)) fin_err++;
        if (fin_periodo) fin_cnt++;
        if (muestra_nueva) mn_seen++;
        if (rx_d && !m_rx_prev && k >= last_cap + 3) begin
            last_cap = k;
            win.push_back(int'(d));
            void'(win.pop_front());
            m_new    = ancho_de_ventana();
            upd_edge = k + 2;
        end
        m_rx_prev = rx_d;
        if ((k % P) == 0) begin
            check("pwm_high_cycles", hi_cnt, m_applied);
            check("pwm_shape_errs", shape_err, 0);
            check("fin_periodo_count", fin_cnt, 1);
            check("fin_periodo_pos_errs", fin_err, 0);
            m_applied = m_pend;
            check("ancho_pulso_after_wrap", ancho_pulso, m_applied);
            hi_cnt    = 0;
            shape_err = 0;
            fin_cnt   = 0;
            fin_err   = 0;
        end
        if (k == upd_edge) begin
            m_pend = m_new;
            mn_exp++;
            check("muestra_nueva_pulse", muestra_nueva, 1);
        end
    endtask

    task automatic run_to_wrap();
        do step(); while ((k % P) != 0);
    endtask

    task automatic run_to_phase(input int ph);
        do step(); while ((k % P) != ph);
    endtask

    task automatic send_frame(input logic [11:0] d, input int hold, input int gap);
        rx_listo     = 1'b1;
        paquete_bits = d;
        repeat (hold) step();
        rx_listo     = 1'b0;
        paquete_bits = 12'($urandom);
        repeat (gap) step();
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm", pwm, 0);
        check("rst_fin_periodo", fin_periodo, 0);
        check("rst_muestra_nueva", muestra_nueva, 0);
        check("rst_ancho_pulso", ancho_pulso, MINC + 2048 * ESC);
        model_reset();
        rst = 1'b0;
        step();
        check("first_pwm_high", pwm, 1);

        // Idle periods at centre width.
        run_to_wrap();
        run_to_wrap();

        // Four zero samples, one per period: width steps down to MIN.
        repeat (4) begin
            send_frame(12'h000, $urandom_range(1, 5), 40);
            run_to_wrap();
        end
        run_to_wrap();
        check("ancho_all_zero", ancho_pulso, MINC);

        // Four full-scale samples: clamp at MAX.
        repeat (4) send_frame(12'hFFF, $urandom_range(1, 5), 30);
        run_to_wrap();
        run_to_wrap();
        check("ancho_clamped", ancho_pulso, MAXC);

        // Asynchronous reset in the middle of a pulse.
        run_to_phase(1000);
        rst = 1'b1;
        #1;
        check("midrst_pwm", pwm, 0);
        check("midrst_fin_periodo", fin_periodo, 0);
        check("midrst_ancho_pulso", ancho_pulso, MINC + 2048 * ESC);
        #1;
        rst = 1'b0;
        model_reset();

        // One zero sample after reset: window must have restarted at CENTRO.
        send_frame(12'h000, 2, 40);
        run_to_wrap();
        check("postrst_ancho", ancho_pulso, MINC + 1536 * ESC);
        run_to_wrap();

        // Long rx_listo level whose update lands on the wrap edge.
        run_to_phase(P - 3);
        send_frame(12'hFFF, 20, 20);
        run_to_wrap();
        run_to_wrap();

        // Random frames.
        repeat (8) send_frame(12'($urandom), $urandom_range(1, 20), $urandom_range(20, 400));
        run_to_wrap();
        run_to_wrap();

        check("muestra_nueva_total", mn_seen, mn_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
